fdiv_sched: RTL and testbench

Programmable divide-by-N tick scheduler that sequences a down-counting divider.
- Accepts a divisor and a burst length over a valid/ready config handshake.
- Emits one-cycle tick pulses every N clk cycles for the programmed number of ticks, then pulses done and returns to idle.
- Sits between control logic and tick-driven datapath blocks as their configurable time base.

---
 rtl/fdiv_sched.sv | 165 ++++++++++++++++
 tb/tb_fdiv_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fdiv_sched.sv
// Programmable divide-by-N tick scheduler: emits cfg_cnt ticks spaced cfg_div cycles apart, then done.
// Optional mid-burst reload shadow register is enabled by defining FDIV_SCHED_RELOAD_EN.
module fdiv_sched #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_div,
  input  logic [CW-1:0] cfg_cnt,
  input  logic          stop,
  output logic          tick,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] ticks_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0]  DIV_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_reg, state_next;
  logic [W-1:0]  phase_reg, phase_next;
  logic [W-1:0]  div_reg, div_next;
  logic [CW-1:0] ticks_left_reg, ticks_left_next;
  logic          tick_reg, tick_next;
  logic          done_reg, done_next;
  logic [W-1:0]  div_eff;
  logic          accept;

`ifdef FDIV_SCHED_RELOAD_EN
  logic          shadow_valid_reg, shadow_valid_next;
  logic [W-1:0]  shadow_div_reg, shadow_div_next;
  logic [CW-1:0] shadow_cnt_reg, shadow_cnt_next;

  assign cfg_ready = (state_reg == IDLE) || ((state_reg == RUN) && !shadow_valid_reg);
`else
  assign cfg_ready = (state_reg == IDLE);
`endif

  // A zero divisor behaves as divide-by-one.
  assign div_eff    = (cfg_div == '0) ? DIV_ONE : cfg_div;
  assign accept     = cfg_valid && cfg_ready;
  assign busy       = (state_reg != IDLE);
  assign tick       = tick_reg;
  assign done       = done_reg;
  assign ticks_left = ticks_left_reg;

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    div_next        = div_reg;
    ticks_left_next = ticks_left_reg;
    tick_next       = 1'b0;
    done_next       = 1'b0;
`ifdef FDIV_SCHED_RELOAD_EN
    shadow_valid_next = shadow_valid_reg;
    shadow_div_next   = shadow_div_reg;
    shadow_cnt_next   = shadow_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          phase_next      = div_eff - DIV_ONE;
          div_next        = div_eff;
          ticks_left_next = cfg_cnt;
          state_next      = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          // Abort wins over any tick or terminal tick on the same edge.
          state_next      = IDLE;
          phase_next      = '0;
          ticks_left_next = '0;
`ifdef FDIV_SCHED_RELOAD_EN
          shadow_valid_next = 1'b0;
`endif
        end else begin
          if (phase_reg == '0) begin
            tick_next = 1'b1;
`ifdef FDIV_SCHED_RELOAD_EN
            if (shadow_valid_reg) begin
              phase_next        = shadow_div_reg - DIV_ONE;
              div_next          = shadow_div_reg;
              ticks_left_next   = shadow_cnt_reg;
              shadow_valid_next = 1'b0;
            end else begin
              phase_next = div_reg - DIV_ONE;
              if (ticks_left_reg != '0) ticks_left_next = ticks_left_reg - CNT_ONE;
              if (ticks_left_reg == CNT_ONE) begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end
`else
            phase_next = div_reg - DIV_ONE;
            if (ticks_left_reg != '0) ticks_left_next = ticks_left_reg - CNT_ONE;
            if (ticks_left_reg == CNT_ONE) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
`endif
          end else begin
            phase_next = phase_reg - DIV_ONE;
          end
`ifdef FDIV_SCHED_RELOAD_EN
          // Accept only happens with an empty shadow, so it never collides with an apply above.
          if (accept) begin
            shadow_valid_next = 1'b1;
            shadow_div_next   = div_eff;
            shadow_cnt_next   = cfg_cnt;
          end
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      div_reg        <= DIV_ONE;
      ticks_left_reg <= '0;
      tick_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef FDIV_SCHED_RELOAD_EN
      shadow_valid_reg <= 1'b0;
      shadow_div_reg   <= DIV_ONE;
      shadow_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      div_reg        <= div_next;
      ticks_left_reg <= ticks_left_next;
      tick_reg       <= tick_next;
      done_reg       <= done_next;
`ifdef FDIV_SCHED_RELOAD_EN
      shadow_valid_reg <= shadow_valid_next;
      shadow_div_reg   <= shadow_div_next;
      shadow_cnt_reg   <= shadow_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_fdiv_sched.sv
// Scoreboard bench for fdiv_sched (base build): expected tick/done events are derived from
// the burst arithmetic (edge = E0 + k*N) and checked by an independent monitor.
module tb_fdiv_sched;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_div = '0;
  logic [CW-1:0] cfg_cnt = '0;
  logic          stop = 1'b0;
  logic          tick;
  logic          done;
  logic          busy;
  logic [CW-1:0] ticks_left;

  fdiv_sched #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_cnt(cfg_cnt), .stop(stop), .tick(tick), .done(done),
    .busy(busy), .ticks_left(ticks_left)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a negedge it names the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_no;
    int tl;
    bit dn;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  earliest = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the next expected event exactly.
  always @(negedge clk) begin
    ev_t e;
    if (rst_b && (tick || done)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got tick=%0b done=%0b at cycle %0d, required no pulse",
                 tick, done, cyc);
      end else begin
        e = q.pop_front();
        if (e.edge_no != cyc || !tick || int'(ticks_left) != e.tl || done != e.dn) begin
          fails++;
          $display("FAIL tick_event: got cycle=%0d tick=%0b ticks_left=%0d done=%0b, required cycle=%0d tick=1 ticks_left=%0d done=%0b",
                   cyc, tick, ticks_left, done, e.edge_no, e.tl, e.dn);
        end
      end
    end
  end

  // Issue one burst; valid is held until the model says the block is idle.
  task automatic run(input int div, input int cnt, input bit do_stop, input int stop_off);
    int n;
    int e0;
    int es;
    ev_t e;
    n = (div == 0) ? 1 : div;
    cfg_valid = 1'b1;
    cfg_div   = W'(div);
    cfg_cnt   = CW'(cnt);
    e0 = (cyc + 1 > earliest) ? cyc + 1 : earliest;
    while (cyc < e0) begin
      chk("cfg_ready_hold", int'(cfg_ready), (cyc >= earliest - 1) ? 1 : 0);
      chk("busy_hold", int'(busy), (cyc >= earliest - 1) ? 0 : 1);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    es = do_stop ? e0 + stop_off : 32'h7fff_ffff;
    for (int k = 1; ; k++) begin
      if (cnt != 0 && k > cnt) break;
      if (e0 + k * n >= es) break;
      e.edge_no = e0 + k * n;
      e.tl      = (cnt == 0) ? 0 : cnt - k;
      e.dn      = (cnt != 0) && (k == cnt);
      q.push_back(e);
    end
    $display("[TB] burst div=%0d cnt=%0d accepted at edge %0d stop=%0b stop_edge=%0d",
             div, cnt, e0, do_stop, do_stop ? es : 0);
    if (do_stop) begin
      while (cyc < es - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("busy_after_stop", int'(busy), 0);
      chk("ticks_left_after_stop", int'(ticks_left), 0);
      earliest = es + 1;
    end else begin
      earliest = e0 + cnt * n + 2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int div;
    int cnt;
    int n;
    int off;
    bit st;

    // Reset held for two edges with a pending request that must not be taken.
    rst_b     = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    cfg_cnt   = 8'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b     = 1'b1;
    cfg_valid = 1'b0;
    chk("rst_tick", int'(tick), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_ticks_left", int'(ticks_left), 0);
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    earliest = cyc + 1;

    run(5, 3, 1'b0, 0);
    run(0, 4, 1'b0, 0);
    run(3, 0, 1'b1, 12);
    run(1, 2, 1'b0, 0);
    run(4, 3, 1'b1, 12);

    for (int t = 0; t < 24; t++) begin
      div = int'($urandom_range(0, 6));
      cnt = int'($urandom_range(0, 4));
      n   = (div == 0) ? 1 : div;
      st  = (cnt == 0) || ($urandom_range(0, 3) == 0);
      off = int'($urandom_range(1, (cnt == 0) ? 3 * n + 2 : cnt * n));
      run(div, cnt, st, off);
    end

    while (cyc < earliest + 1) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    chk("final_cfg_ready", int'(cfg_ready), 1);
    chk("final_pending_events", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
